sdram_arb: RTL and testbench

SDRAM_ARB -- requirements
Module: sdram_arb

---
 rtl/sdram_arb.sv | 189 ++++++++++++++++++
 tb/tb_sdram_arb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arb.sv
// Two-client round-robin arbiter in front of a single SDRAM interface.
// One transaction in flight at a time, with a watchdog on ack and read-data waits.
module sdram_arb #(
   parameter int BURST   = 1,
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c0_req,
   input  logic        c1_req,
   input  logic        c0_we,
   input  logic        c1_we,
   input  logic [1:0]  c0_bank,
   input  logic [1:0]  c1_bank,
   input  logic [12:0] c0_addr,
   input  logic [12:0] c1_addr,
   input  logic [15:0] c0_wdata,
   input  logic [15:0] c1_wdata,
   output logic        c0_ack,
   output logic        c1_ack,
   output logic [15:0] c0_rdata,
   output logic [15:0] c1_rdata,
   output logic        c0_rdata_vld,
   output logic        c1_rdata_vld,
   output logic        wr_req,
   output logic        rd_req,
   output logic [1:0]  bank,
   output logic [12:0] addr,
   output logic [15:0] wdata,
   input  logic        wr_ack,
   input  logic        rd_ack,
   input  logic [15:0] rdata,
   input  logic        rdata_vld,
   output logic        err,
   output logic        owner
);

   localparam logic [1:0]  IDLE          = 2'd0;
   localparam logic [1:0]  ISSUE         = 2'd1;
   localparam logic [1:0]  RDWAIT        = 2'd2;
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT);
   localparam logic [7:0]  LAST_BEAT     = 8'(BURST - 1);

   // Per-client views of the request ports, indexed by client number.
   logic [1:0]  req_vec;
   logic [1:0]  we_vec;
   logic [1:0]  bank_vec  [2];
   logic [12:0] addr_vec  [2];
   logic [15:0] wdata_vec [2];
   logic [1:0]  ack_vec;
   logic [1:0]  vld_vec;

   logic [1:0]  state_reg,      state_next;
   logic        last_grant_reg, last_grant_next;
   logic        owner_reg,      owner_next;
   logic        we_reg,         we_next;
   logic [1:0]  bank_reg,       bank_next;
   logic [12:0] addr_reg,       addr_next;
   logic [15:0] wdata_reg,      wdata_next;
   logic [15:0] wd_reg,         wd_next;
   logic [7:0]  beat_reg,       beat_next;

   logic in_issue;
   logic in_rdwait;
   logic match_ack;
   logic ack_fire;
   logic wd_hit;
   logic last_beat;
   logic err_fire;
   logic grant_id;

   assign req_vec      = {c1_req, c0_req};
   assign we_vec       = {c1_we, c0_we};
   assign bank_vec[0]  = c0_bank;
   assign bank_vec[1]  = c1_bank;
   assign addr_vec[0]  = c0_addr;
   assign addr_vec[1]  = c1_addr;
   assign wdata_vec[0] = c0_wdata;
   assign wdata_vec[1] = c1_wdata;

   assign in_issue  = (state_reg == ISSUE);
   assign in_rdwait = (state_reg == RDWAIT);
   assign match_ack = we_reg ? wr_ack : rd_ack;
   assign ack_fire  = in_issue && match_ack;
   assign wd_hit    = (in_issue || in_rdwait) && (wd_reg == TIMEOUT_LIMIT);
   assign last_beat = in_rdwait && rdata_vld && (beat_reg == LAST_BEAT);
   // A completing ack or final beat in the same cycle as the watchdog wins.
   assign err_fire  = wd_hit && !ack_fire && !last_beat;
   assign grant_id  = (&req_vec) ? ~last_grant_reg : req_vec[1];

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      owner_next      = owner_reg;
      we_next         = we_reg;
      bank_next       = bank_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      wd_next         = wd_reg;
      beat_next       = beat_reg;
      case (state_reg)
         IDLE: begin
            if (|req_vec) begin
               owner_next = grant_id;
               we_next    = we_vec[grant_id];
               bank_next  = bank_vec[grant_id];
               addr_next  = addr_vec[grant_id];
               wdata_next = wdata_vec[grant_id];
               wd_next    = '0;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            wd_next = wd_reg + 16'd1;
            if (ack_fire) begin
               last_grant_next = owner_reg;
               wd_next         = '0;
               beat_next       = '0;
               state_next      = we_reg ? IDLE : RDWAIT;
            end else if (wd_hit) begin
               last_grant_next = owner_reg;
               state_next      = IDLE;
            end
         end
         RDWAIT: begin
            wd_next = wd_reg + 16'd1;
            if (rdata_vld) begin
               beat_next = beat_reg + 8'd1;
            end
            if (last_beat || wd_hit) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         owner_reg      <= 1'b0;
         we_reg         <= 1'b0;
         bank_reg       <= '0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         wd_reg         <= '0;
         beat_reg       <= '0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         owner_reg      <= owner_next;
         we_reg         <= we_next;
         bank_reg       <= bank_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         wd_reg         <= wd_next;
         beat_reg       <= beat_next;
      end
   end

   // Acks and read-data valids are steered to the owning client only.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_client
         assign ack_vec[gi] = !rst && ack_fire && (owner_reg == 1'(gi));
         assign vld_vec[gi] = !rst && in_rdwait && rdata_vld && (owner_reg == 1'(gi));
      end
   endgenerate

   assign c0_ack       = ack_vec[0];
   assign c1_ack       = ack_vec[1];
   assign c0_rdata_vld = vld_vec[0];
   assign c1_rdata_vld = vld_vec[1];
   assign c0_rdata     = rdata;
   assign c1_rdata     = rdata;

   // Requests fall in the very cycle the ack or timeout is seen.
   assign wr_req = !rst && in_issue && we_reg && !wr_ack && !wd_hit;
   assign rd_req = !rst && in_issue && !we_reg && !rd_ack && !wd_hit;
   assign bank   = rst ? '0 : bank_reg;
   assign addr   = rst ? '0 : addr_reg;
   assign wdata  = rst ? '0 : wdata_reg;
   assign err    = !rst && err_fire;
   assign owner  = owner_reg;

endmodule

// File: tb/tb_sdram_arb.sv
// Bench for sdram_arb (BURST=4, TIMEOUT=8): directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_sdram_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        c0_req, c1_req, c0_we, c1_we;
   logic [1:0]  c0_bank, c1_bank;
   logic [12:0] c0_addr, c1_addr;
   logic [15:0] c0_wdata, c1_wdata;
   logic        c0_ack, c1_ack;
   logic [15:0] c0_rdata, c1_rdata;
   logic        c0_rdata_vld, c1_rdata_vld;
   logic        wr_req, rd_req;
   logic [1:0]  bank;
   logic [12:0] addr;
   logic [15:0] wdata;
   logic        wr_ack, rd_ack;
   logic [15:0] rdata;
   logic        rdata_vld;
   logic        err, owner;

   int checks = 0;
   int passed = 0;
   logic model_last = 1'b1;

   always #5 clk = ~clk;

   sdram_arb #(.BURST(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .c0_req(c0_req), .c1_req(c1_req), .c0_we(c0_we), .c1_we(c1_we),
      .c0_bank(c0_bank), .c1_bank(c1_bank), .c0_addr(c0_addr), .c1_addr(c1_addr),
      .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
      .c0_ack(c0_ack), .c1_ack(c1_ack), .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
      .c0_rdata_vld(c0_rdata_vld), .c1_rdata_vld(c1_rdata_vld),
      .wr_req(wr_req), .rd_req(rd_req), .bank(bank), .addr(addr), .wdata(wdata),
      .wr_ack(wr_ack), .rd_ack(rd_ack), .rdata(rdata), .rdata_vld(rdata_vld),
      .err(err), .owner(owner)
   );

   task automatic clear_inputs();
      c0_req = 0; c1_req = 0; c0_we = 0; c1_we = 0;
      c0_bank = 0; c1_bank = 0; c0_addr = 0; c1_addr = 0; c0_wdata = 0; c1_wdata = 0;
      wr_ack = 0; rd_ack = 0; rdata = 0; rdata_vld = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      c0_req = 1; c0_we = 1; wr_ack = 1; rd_ack = 1; rdata_vld = 1; rdata = 16'hBEEF;
      #1;
      checks++; if ({wr_req, rd_req, c0_ack, c1_ack, c0_rdata_vld, c1_rdata_vld, err} !== 7'b0)
         $display("FAIL reset_ctrl: got %b want 0000000", {wr_req, rd_req, c0_ack, c1_ack, c0_rdata_vld, c1_rdata_vld, err}); else passed++;
      checks++; if ({bank, addr, wdata} !== 31'b0)
         $display("FAIL reset_bus: got %h want 0", {bank, addr, wdata}); else passed++;
      checks++; if (owner !== 1'b0) $display("FAIL reset_owner: got %b want 0", owner); else passed++;
      checks++; if (c1_rdata !== 16'hBEEF) $display("FAIL reset_rdata_pass: got %h want beef", c1_rdata); else passed++;
      @(negedge clk);
      rst = 0; clear_inputs();
      model_last = 1'b1;
   endtask

   task automatic test_round_robin();
      @(negedge clk);
      c0_req = 1; c0_we = 1; c0_bank = 2'd1; c0_addr = 13'h0AA;  c0_wdata = 16'h1111;
      c1_req = 1; c1_we = 1; c1_bank = 2'd3; c1_addr = 13'h1234; c1_wdata = 16'h2222;
      @(negedge clk); #1;
      checks++; if (owner !== 1'b0) $display("FAIL rr_first_owner: got %b want 0", owner); else passed++;
      checks++; if ({wr_req, rd_req} !== 2'b10) $display("FAIL rr_first_req: got %b want 10", {wr_req, rd_req}); else passed++;
      checks++; if ({bank, addr, wdata} !== {2'd1, 13'h0AA, 16'h1111})
         $display("FAIL rr_first_bus: got %h want %h", {bank, addr, wdata}, {2'd1, 13'h0AA, 16'h1111}); else passed++;
      @(negedge clk); wr_ack = 1; #1;
      checks++; if ({c0_ack, c1_ack, wr_req, err} !== 4'b1000)
         $display("FAIL rr_first_ack: got %b want 1000", {c0_ack, c1_ack, wr_req, err}); else passed++;
      model_last = 1'b0;
      @(negedge clk); wr_ack = 0; #1;
      checks++; if ({wr_req, c0_ack} !== 2'b00) $display("FAIL rr_idle_gap: got %b want 00", {wr_req, c0_ack}); else passed++;
      @(negedge clk); #1;
      checks++; if (owner !== 1'b1) $display("FAIL rr_second_owner: got %b want 1", owner); else passed++;
      checks++; if ({wr_req, bank, addr, wdata} !== {1'b1, 2'd3, 13'h1234, 16'h2222})
         $display("FAIL rr_second_bus: got %h want %h", {wr_req, bank, addr, wdata}, {1'b1, 2'd3, 13'h1234, 16'h2222}); else passed++;
      @(negedge clk); wr_ack = 1; #1;
      checks++; if ({c0_ack, c1_ack} !== 2'b01) $display("FAIL rr_second_ack: got %b want 01", {c0_ack, c1_ack}); else passed++;
      model_last = 1'b1;
      @(negedge clk); clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_read_burst();
      logic [3:0] pattern;
      pattern = 4'b0000;
      c1_req = 1; c1_we = 0; c1_bank = 2'd2; c1_addr = 13'h155;
      @(negedge clk); #1;
      checks++; if ({rd_req, wr_req, bank, addr, owner} !== {1'b1, 1'b0, 2'd2, 13'h155, 1'b1})
         $display("FAIL rd_issue: got %h want %h", {rd_req, wr_req, bank, addr, owner}, {1'b1, 1'b0, 2'd2, 13'h155, 1'b1}); else passed++;
      @(negedge clk); wr_ack = 1; #1;
      checks++; if ({rd_req, c1_ack, c0_ack} !== 3'b100)
         $display("FAIL rd_wrong_ack_ignored: got %b want 100", {rd_req, c1_ack, c0_ack}); else passed++;
      @(negedge clk); wr_ack = 0; rd_ack = 1; #1;
      checks++; if ({rd_req, c1_ack, c0_ack} !== 3'b010)
         $display("FAIL rd_ack: got %b want 010", {rd_req, c1_ack, c0_ack}); else passed++;
      model_last = 1'b1;
      @(negedge clk); rd_ack = 0; c1_req = 0;
      // Five RDWAIT slots: beat, gap, beat, beat, beat.
      for (int s = 0; s < 5; s++) begin
         rdata_vld = (s != 1);
         rdata = 16'hA000 + 16'(s);
         #1;
         checks++; if ({c1_rdata_vld, c0_rdata_vld} !== {rdata_vld, 1'b0} || c1_rdata !== rdata)
            $display("FAIL rd_beat%0d: got vld=%b%b data=%h want vld=%b0 data=%h", s, c1_rdata_vld, c0_rdata_vld, c1_rdata, rdata_vld, rdata); else passed++;
         if (c1_rdata_vld === 1'b1) pattern = {pattern[2:0], 1'b1};
         @(negedge clk);
      end
      checks++; if (pattern !== 4'b1111) $display("FAIL rd_beat_count: got %b want 1111", pattern); else passed++;
      rdata_vld = 1; #1;
      checks++; if ({c1_rdata_vld, c0_rdata_vld} !== 2'b00)
         $display("FAIL rd_stray_beat: got %b want 00", {c1_rdata_vld, c0_rdata_vld}); else passed++;
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_starvation();
      int c1_idx;
      logic exp_own;
      c1_idx = -1;
      c0_req = 1; c0_we = 1; c1_req = 1; c1_we = 1;
      for (int g = 0; g < 3; g++) begin
         exp_own = c1_req ? ~model_last : 1'b0;
         @(negedge clk); #1;
         checks++; if (owner !== exp_own) $display("FAIL starve_owner%0d: got %b want %b", g, owner, exp_own); else passed++;
         if (owner === 1'b1 && c1_idx < 0) c1_idx = g;
         wr_ack = 1;
         model_last = exp_own;
         @(negedge clk); wr_ack = 0;
         if (exp_own) c1_req = 0;
      end
      checks++; if (c1_idx < 0 || c1_idx > 1) $display("FAIL starve_c1_grant: got index %0d want 0..1", c1_idx); else passed++;
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_timeout();
      c0_req = 1; c0_we = 1; c0_addr = 13'h77;
      @(negedge clk); c0_req = 0;
      for (int k = 0; k < 8; k++) begin
         #1;
         checks++; if ({wr_req, err, c0_ack} !== 3'b100)
            $display("FAIL to_wait%0d: got %b want 100", k, {wr_req, err, c0_ack}); else passed++;
         @(negedge clk);
      end
      #1;
      checks++; if ({err, wr_req, c0_ack, c1_ack} !== 4'b1000)
         $display("FAIL to_fire: got %b want 1000", {err, wr_req, c0_ack, c1_ack}); else passed++;
      model_last = 1'b0;
      @(negedge clk); #1;
      checks++; if ({err, wr_req} !== 2'b00) $display("FAIL to_after: got %b want 00", {err, wr_req}); else passed++;
      clear_inputs();
   endtask

   task automatic test_ack_vs_timeout();
      logic exp_own;
      exp_own = ~model_last;
      c0_req = 1; c0_we = 1; c1_req = 1; c1_we = 1;
      @(negedge clk); c0_req = 0; c1_req = 0; #1;
      checks++; if (owner !== exp_own) $display("FAIL avt_owner: got %b want %b", owner, exp_own); else passed++;
      repeat (8) @(negedge clk);
      wr_ack = 1; #1;
      checks++; if ({c0_ack, c1_ack, err, wr_req} !== {~exp_own, exp_own, 1'b0, 1'b0})
         $display("FAIL avt_ack_wins: got %b want %b", {c0_ack, c1_ack, err, wr_req}, {~exp_own, exp_own, 2'b00}); else passed++;
      model_last = exp_own;
      @(negedge clk); clear_inputs(); #1;
      checks++; if (err !== 1'b0) $display("FAIL avt_no_err_after: got %b want 0", err); else passed++;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [1:0]  reqs, we2, bk0, bk1;
      logic [12:0] ad0, ad1;
      logic [15:0] wd0, wd1;
      logic        win, vld;
      int          lat, gap, remaining;
      for (int t = 0; t < 40; t++) begin
         reqs = 2'($urandom_range(1, 3));
         we2 = 2'($urandom);
         bk0 = 2'($urandom); bk1 = 2'($urandom);
         ad0 = 13'($urandom); ad1 = 13'($urandom);
         wd0 = 16'($urandom); wd1 = 16'($urandom);
         win = (reqs == 2'b11) ? ~model_last : reqs[1];
         c0_req = reqs[0]; c0_we = we2[0]; c0_bank = bk0; c0_addr = ad0; c0_wdata = wd0;
         c1_req = reqs[1]; c1_we = we2[1]; c1_bank = bk1; c1_addr = ad1; c1_wdata = wd1;
         @(negedge clk); c0_req = 0; c1_req = 0; #1;
         checks++; if (owner !== win || {wr_req, rd_req} !== {we2[win], ~we2[win]}
                       || {bank, addr, wdata} !== (win ? {bk1, ad1, wd1} : {bk0, ad0, wd0}))
            $display("FAIL rand%0d_issue: got own=%b req=%b%b bus=%h want own=%b we=%b bus=%h", t, owner, wr_req, rd_req,
                     {bank, addr, wdata}, win, we2[win], win ? {bk1, ad1, wd1} : {bk0, ad0, wd0}); else passed++;
         lat = $urandom_range(0, 4);
         for (int k = 0; k < lat; k++) begin
            if (we2[win]) rd_ack = 1'($urandom); else wr_ack = 1'($urandom);
            #1;
            checks++; if ({wr_req, rd_req, c0_ack, c1_ack, err} !== {we2[win], ~we2[win], 3'b000})
               $display("FAIL rand%0d_hold%0d: got %b want %b", t, k, {wr_req, rd_req, c0_ack, c1_ack, err}, {we2[win], ~we2[win], 3'b000}); else passed++;
            @(negedge clk); wr_ack = 0; rd_ack = 0;
         end
         if (we2[win]) wr_ack = 1; else rd_ack = 1;
         #1;
         checks++; if ({c0_ack, c1_ack, wr_req, rd_req, err} !== {~win, win, 3'b000})
            $display("FAIL rand%0d_ack: got %b want %b", t, {c0_ack, c1_ack, wr_req, rd_req, err}, {~win, win, 3'b000}); else passed++;
         model_last = win;
         @(negedge clk); wr_ack = 0; rd_ack = 0;
         if (!we2[win]) begin
            remaining = 4;
            gap = $urandom_range(0, 1);
            while (remaining > 0) begin
               if (gap == 0) begin
                  vld = 1; remaining--; gap = $urandom_range(0, 1);
               end else begin
                  vld = 0; gap--;
               end
               rdata_vld = vld; rdata = 16'($urandom);
               #1;
               checks++; if ({c0_rdata_vld, c1_rdata_vld} !== {vld & ~win, vld & win} || c0_rdata !== rdata || c1_rdata !== rdata)
                  $display("FAIL rand%0d_beat: got vld=%b%b want %b%b", t, c0_rdata_vld, c1_rdata_vld, vld & ~win, vld & win); else passed++;
               @(negedge clk);
            end
            rdata_vld = 0;
         end
         #1;
         checks++; if ({wr_req, rd_req, err} !== 3'b000) $display("FAIL rand%0d_idle: got %b want 000", t, {wr_req, rd_req, err}); else passed++;
      end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_reset_mid_read();
      c0_req = 1; c0_we = 0; c0_bank = 2'd1; c0_addr = 13'h321;
      @(negedge clk); c0_req = 0; rd_ack = 1; #1;
      checks++; if (c0_ack !== 1'b1) $display("FAIL rmr_ack: got %b want 1", c0_ack); else passed++;
      for (int b = 0; b < 2; b++) begin
         @(negedge clk); rd_ack = 0; rdata_vld = 1; rdata = 16'h5A00 + 16'(b); #1;
         checks++; if (c0_rdata_vld !== 1'b1) $display("FAIL rmr_beat%0d: got %b want 1", b, c0_rdata_vld); else passed++;
      end
      @(negedge clk); rst = 1; #1;
      checks++; if ({wr_req, rd_req, c0_ack, c1_ack, c0_rdata_vld, c1_rdata_vld, err, bank, addr, wdata} !== 38'b0)
         $display("FAIL rmr_during_rst: got %h want 0", {wr_req, rd_req, c0_ack, c1_ack, c0_rdata_vld, c1_rdata_vld, err, bank, addr, wdata}); else passed++;
      @(negedge clk); rst = 0; #1;
      checks++; if ({wr_req, rd_req, c0_ack, c1_ack, c0_rdata_vld, c1_rdata_vld, err, bank, addr, wdata, owner} !== 39'b0)
         $display("FAIL rmr_after_rst: got %h want 0", {wr_req, rd_req, c0_ack, c1_ack, c0_rdata_vld, c1_rdata_vld, err, bank, addr, wdata, owner}); else passed++;
      @(negedge clk); #1;
      checks++; if ({c0_rdata_vld, err} !== 2'b00) $display("FAIL rmr_beats_dropped: got %b want 00", {c0_rdata_vld, err}); else passed++;
      clear_inputs();
      model_last = 1'b1;
      c0_req = 1; c0_we = 1; c1_req = 1; c1_we = 1;
      @(negedge clk); c0_req = 0; c1_req = 0; #1;
      checks++; if ({owner, wr_req} !== 2'b01) $display("FAIL rmr_regrant: got %b want 01", {owner, wr_req}); else passed++;
      wr_ack = 1;
      @(negedge clk); clear_inputs();
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1;
      clear_inputs();
      test_reset();
      test_round_robin();
      test_read_burst();
      test_starvation();
      test_timeout();
      test_ack_vs_timeout();
      test_random();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
